// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: PC, IF/ID and ID/EX stages with stall/flush
// control and saturating hazard event counters.
module pipe_front_regs (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushE,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] InstrF,
    input  logic [7:0]  CtrlD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] SignImmD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic [7:0]  CtrlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] SignImmE,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic        ValidE,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CTRLW = 8;
    localparam int unsigned REGW  = 5;
    localparam int unsigned CNTW  = 16;

    logic [XLEN-1:0]  r_pcf;
    logic [XLEN-1:0]  r_instr_d;
    logic [XLEN-1:0]  r_pcplus4_d;
    logic [CTRLW-1:0] r_ctrl_e;
    logic [XLEN-1:0]  r_rd1_e;
    logic [XLEN-1:0]  r_rd2_e;
    logic [XLEN-1:0]  r_signimm_e;
    logic [REGW-1:0]  r_rs_e;
    logic [REGW-1:0]  r_rt_e;
    logic [REGW-1:0]  r_rd_e;
    logic             r_valid_e;
    logic [CNTW-1:0]  r_stall_cnt;
    logic [CNTW-1:0]  r_flush_cnt;

    logic [XLEN-1:0]  w_pcplus4;
    logic             w_flush_evt;

    assign w_pcplus4   = r_pcf + XLEN'(4);
    // A decode-stage branch squash only counts when IF/ID actually updates.
    assign w_flush_evt = FlushE | (PCSrcD & ~StallD);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_pcf       <= '0;
            r_instr_d   <= '0;
            r_pcplus4_d <= '0;
            r_ctrl_e    <= '0;
            r_rd1_e     <= '0;
            r_rd2_e     <= '0;
            r_signimm_e <= '0;
            r_rs_e      <= '0;
            r_rt_e      <= '0;
            r_rd_e      <= '0;
            r_valid_e   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // StallF outranks a taken branch.
            if (!StallF) begin
                r_pcf <= PCSrcD ? PCBranchD : w_pcplus4;
            end

            if (!StallD) begin
                r_instr_d   <= PCSrcD ? '0 : InstrF;
                r_pcplus4_d <= PCSrcD ? '0 : w_pcplus4;
            end

            // ID/EX has no hold path; a flush loads a bubble.
            if (FlushE) begin
                r_ctrl_e    <= '0;
                r_rd1_e     <= '0;
                r_rd2_e     <= '0;
                r_signimm_e <= '0;
                r_rs_e      <= '0;
                r_rt_e      <= '0;
                r_rd_e      <= '0;
                r_valid_e   <= 1'b0;
            end else begin
                r_ctrl_e    <= CtrlD;
                r_rd1_e     <= RD1D;
                r_rd2_e     <= RD2D;
                r_signimm_e <= SignImmD;
                r_rs_e      <= RsD;
                r_rt_e      <= RtD;
                r_rd_e      <= RdD;
                r_valid_e   <= 1'b1;
            end

            if (StallD && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
            end
        end
    end

    assign PCF        = r_pcf;
    assign InstrD     = r_instr_d;
    assign PCPlus4D   = r_pcplus4_d;
    assign CtrlE      = r_ctrl_e;
    assign RD1E       = r_rd1_e;
    assign RD2E       = r_rd2_e;
    assign SignImmE   = r_signimm_e;
    assign RsE        = r_rs_e;
    assign RtE        = r_rt_e;
    assign RdE        = r_rd_e;
    assign ValidE     = r_valid_e;
    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed self-checking bench for pipe_front_regs.
module tb_pipe_front_regs;

    logic        Clk = 1'b0;
    logic        Reset_n, StallF, StallD, FlushE, PCSrcD;
    logic [31:0] PCBranchD, InstrF, RD1D, RD2D, SignImmD;
    logic [7:0]  CtrlD;
    logic [4:0]  RsD, RtD, RdD;
    logic [31:0] PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE;
    logic [7:0]  CtrlE;
    logic [4:0]  RsE, RtE, RdE;
    logic        ValidE;
    logic [15:0] StallCount, FlushCount;

    int n_checks = 0;
    int n_errors = 0;

    pipe_front_regs dut (
        .Clk(Clk), .Reset_n(Reset_n), .StallF(StallF), .StallD(StallD),
        .FlushE(FlushE), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .InstrF(InstrF),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .CtrlE(CtrlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .ValidE(ValidE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0; PCSrcD = 1'b0;
        PCBranchD = '0; InstrF = '0; CtrlD = '0; RD1D = '0; RD2D = '0; SignImmD = '0;
        RsD = '0; RtD = '0; RdD = '0;
        step(); step();

        chk("rst_pcf", PCF, 32'h0);
        chk("rst_instrd", InstrD, 32'h0);
        chk("rst_pcp4d", PCPlus4D, 32'h0);
        chk("rst_ctrle", 32'(CtrlE), 32'h0);
        chk("rst_valide", 32'(ValidE), 32'h0);
        chk("rst_stallcnt", 32'(StallCount), 32'h0);
        chk("rst_flushcnt", 32'(FlushCount), 32'h0);

        // Release with no hazards; decode operands propagate to EX.
        Reset_n = 1'b1; InstrF = 32'h2002_0005;
        CtrlD = 8'hA5; RD1D = 32'h1111_2222; RD2D = 32'h3333_4444;
        SignImmD = 32'hFFFF_FFF0; RsD = 5'd3; RtD = 5'd17; RdD = 5'd31;
        step();
        chk("seq_pcf4", PCF, 32'h4);
        chk("seq_instrd", InstrD, 32'h2002_0005);
        chk("seq_pcp4d", PCPlus4D, 32'h4);
        chk("seq_ctrle", 32'(CtrlE), 32'hA5);
        chk("seq_rd1e", RD1E, 32'h1111_2222);
        chk("seq_rd2e", RD2E, 32'h3333_4444);
        chk("seq_immE", SignImmE, 32'hFFFF_FFF0);
        chk("seq_rse", 32'(RsE), 32'd3);
        chk("seq_rte", 32'(RtE), 32'd17);
        chk("seq_rde", 32'(RdE), 32'd31);
        chk("seq_valide", 32'(ValidE), 32'h1);
        step();
        chk("seq_pcf8", PCF, 32'h8);
        chk("seq_pcp4d_8", PCPlus4D, 32'h8);
        step();
        chk("seq_pcf12", PCF, 32'hC);
        step();
        chk("seq_pcf16", PCF, 32'h10);

        // Load-use stall at PCF=0x10.
        StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1; InstrF = 32'hDEAD_BEEF;
        step();
        chk("lu_pcf_hold", PCF, 32'h10);
        chk("lu_instrd_hold", InstrD, 32'h2002_0005);
        chk("lu_pcp4d_hold", PCPlus4D, 32'h10);
        chk("lu_ctrle", 32'(CtrlE), 32'h0);
        chk("lu_rd1e", RD1E, 32'h0);
        chk("lu_valide", 32'(ValidE), 32'h0);
        chk("lu_stallcnt", 32'(StallCount), 32'h1);
        chk("lu_flushcnt", 32'(FlushCount), 32'h1);
        StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
        step();
        chk("lu_rel_pcf", PCF, 32'h14);
        chk("lu_rel_instrd", InstrD, 32'hDEAD_BEEF);
        chk("lu_rel_pcp4d", PCPlus4D, 32'h14);
        chk("lu_rel_valide", 32'(ValidE), 32'h1);
        chk("lu_rel_flushcnt", 32'(FlushCount), 32'h1);

        // Taken branch to 0x40.
        PCSrcD = 1'b1; PCBranchD = 32'h40;
        step();
        chk("br_pcf", PCF, 32'h40);
        chk("br_instrd", InstrD, 32'h0);
        chk("br_pcp4d", PCPlus4D, 32'h0);
        chk("br_flushcnt", 32'(FlushCount), 32'h2);
        chk("br_valide", 32'(ValidE), 32'h1);

        // Branch and FlushE together count once.
        FlushE = 1'b1; PCBranchD = 32'h100;
        step();
        chk("dbl_flushcnt", 32'(FlushCount), 32'h3);
        chk("dbl_pcf", PCF, 32'h100);
        chk("dbl_valide", 32'(ValidE), 32'h0);
        FlushE = 1'b0; PCSrcD = 1'b0;
        step();
        chk("dbl_rel_pcf", PCF, 32'h104);
        chk("dbl_rel_instrd", InstrD, 32'hDEAD_BEEF);
        chk("dbl_rel_pcp4d", PCPlus4D, 32'h104);

        // Branch while stalled: nothing in front moves.
        StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h200;
        step();
        chk("bst_pcf", PCF, 32'h104);
        chk("bst_instrd", InstrD, 32'hDEAD_BEEF);
        chk("bst_pcp4d", PCPlus4D, 32'h104);
        chk("bst_flushcnt", 32'(FlushCount), 32'h3);
        chk("bst_stallcnt", 32'(StallCount), 32'h2);

        // Branch to 0x80, then stall there and reset mid-stall.
        StallF = 1'b0; StallD = 1'b0; PCBranchD = 32'h80;
        step();
        chk("r39_pcf80", PCF, 32'h80);
        chk("r39_flushcnt", 32'(FlushCount), 32'h4);
        StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b0;
        step();
        chk("r39_hold80", PCF, 32'h80);
        chk("r39_stallcnt", 32'(StallCount), 32'h3);
        #2;
        Reset_n = 1'b0; FlushE = 1'b1; PCSrcD = 1'b1;
        #1;
        chk("async_pcf", PCF, 32'h80);
        chk("async_stallcnt", 32'(StallCount), 32'h3);
        step();
        chk("r39_rst_pcf", PCF, 32'h0);
        chk("r39_rst_instrd", InstrD, 32'h0);
        chk("r39_rst_pcp4d", PCPlus4D, 32'h0);
        chk("r39_rst_rd2e", RD2E, 32'h0);
        chk("r39_rst_valide", 32'(ValidE), 32'h0);
        chk("r39_rst_stallcnt", 32'(StallCount), 32'h0);
        chk("r39_rst_flushcnt", 32'(FlushCount), 32'h0);
        Reset_n = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0; PCSrcD = 1'b0;
        step();
        chk("r39_rel_pcf", PCF, 32'h4);
        chk("r39_rel_valide", 32'(ValidE), 32'h1);

        // Long stall+flush: both counters saturate.
        StallD = 1'b1; FlushE = 1'b1;
        repeat (65534) @(posedge Clk);
        #1;
        chk("sat_stall_fffe", 32'(StallCount), 32'hFFFE);
        chk("sat_flush_fffe", 32'(FlushCount), 32'hFFFE);
        step();
        chk("sat_stall_ffff", 32'(StallCount), 32'hFFFF);
        chk("sat_flush_ffff", 32'(FlushCount), 32'hFFFF);
        repeat (4465) @(posedge Clk);
        #1;
        chk("sat_stall_hold", 32'(StallCount), 32'hFFFF);
        chk("sat_flush_hold", 32'(FlushCount), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
